// File: rtl/alu_ctrl_pkg.sv
// Shared constants, state encoding and the single-step decode for alu_ctrl_seq.
// Under ALUop 2, funct 0x00/0x02/0x03 (SLL/SRL/SRA) become multi-step shifts.
package alu_ctrl_pkg;

    localparam int CODE_W = 6;

    localparam logic [4:0] ALUOP_ADD   = 5'd0;
    localparam logic [4:0] ALUOP_SUB   = 5'd1;
    localparam logic [4:0] ALUOP_RTYPE = 5'd2;
    localparam logic [4:0] ALUOP_ADDU  = 5'd3;
    localparam logic [4:0] ALUOP_AND   = 5'd4;
    localparam logic [4:0] ALUOP_OR    = 5'd5;
    localparam logic [4:0] ALUOP_XOR   = 5'd6;
    localparam logic [4:0] ALUOP_SLT   = 5'd7;
    localparam logic [4:0] ALUOP_SLTU  = 5'd8;
    localparam logic [4:0] ALUOP_LUI   = 5'd9;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;
    localparam logic [5:0] FUNCT_X30   = 6'h30;
    localparam logic [5:0] FUNCT_X32   = 6'h32;

    localparam logic [5:0] CODE_NOP   = 6'h00;
    localparam logic [5:0] CODE_AND   = 6'h00;
    localparam logic [5:0] CODE_OR    = 6'h01;
    localparam logic [5:0] CODE_ADD   = 6'h02;
    localparam logic [5:0] CODE_ADDU  = 6'h03;
    localparam logic [5:0] CODE_XOR   = 6'h04;
    localparam logic [5:0] CODE_SUB   = 6'h06;
    localparam logic [5:0] CODE_SLT   = 6'h07;
    localparam logic [5:0] CODE_SLTU  = 6'h08;
    localparam logic [5:0] CODE_LUI   = 6'h09;
    localparam logic [5:0] CODE_SLL1  = 6'h0A;
    localparam logic [5:0] CODE_SRL1  = 6'h0D;
    localparam logic [5:0] CODE_SRA1  = 6'h10;
    localparam logic [5:0] CODE_MULTU = 6'h13;
    localparam logic [5:0] CODE_X30   = 6'h30;
    localparam logic [5:0] CODE_X32   = 6'h32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // Primitive amount select: 0 = by 1, 1 = by 2, 2 = by 8.
    localparam logic [1:0] AMT_1 = 2'd0;
    localparam logic [1:0] AMT_2 = 2'd1;
    localparam logic [1:0] AMT_8 = 2'd2;

    typedef enum logic [1:0] {SK_SLL = 2'd0, SK_SRL = 2'd1, SK_SRA = 2'd2} shift_kind_e;

    typedef struct packed {
        logic        is_shift;
        shift_kind_e kind;
        logic [5:0]  code;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [4:0] alu_op, input logic [5:0] funct);
        op_dec_t d;
        d.is_shift = 1'b0;
        d.kind     = SK_SLL;
        d.code     = CODE_NOP;
        case (alu_op)
            ALUOP_ADD:  d.code = CODE_ADD;
            ALUOP_SUB:  d.code = CODE_SUB;
            ALUOP_ADDU: d.code = CODE_ADDU;
            ALUOP_AND:  d.code = CODE_AND;
            ALUOP_OR:   d.code = CODE_OR;
            ALUOP_XOR:  d.code = CODE_XOR;
            ALUOP_SLT:  d.code = CODE_SLT;
            ALUOP_SLTU: d.code = CODE_SLTU;
            ALUOP_LUI:  d.code = CODE_LUI;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_SLL:   begin d.is_shift = 1'b1; d.kind = SK_SLL; end
                    FUNCT_SRL:   begin d.is_shift = 1'b1; d.kind = SK_SRL; end
                    FUNCT_SRA:   begin d.is_shift = 1'b1; d.kind = SK_SRA; end
                    FUNCT_ADD:   d.code = CODE_ADD;
                    FUNCT_ADDU:  d.code = CODE_ADDU;
                    FUNCT_SUBU:  d.code = CODE_SUB;
                    FUNCT_AND:   d.code = CODE_AND;
                    FUNCT_OR:    d.code = CODE_OR;
                    FUNCT_XOR:   d.code = CODE_XOR;
                    FUNCT_SLT:   d.code = CODE_SLT;
                    FUNCT_SLTU:  d.code = CODE_SLTU;
                    FUNCT_MULTU: d.code = CODE_MULTU;
                    FUNCT_MFHI, FUNCT_MFLO: d.code = CODE_NOP;
                    FUNCT_X30:   d.code = CODE_X30;
                    FUNCT_X32:   d.code = CODE_X32;
                    default:     d.code = CODE_NOP;
                endcase
            end
            default: d.code = CODE_NOP;
        endcase
        return d;
    endfunction

    function automatic logic [5:0] prim_code(input shift_kind_e kind, input logic [1:0] amt);
        logic [5:0] base;
        case (kind)
            SK_SRL:  base = CODE_SRL1;
            SK_SRA:  base = CODE_SRA1;
            default: base = CODE_SLL1;
        endcase
        return base + {4'b0000, amt};
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_split.sv
// Splits a shift amount into counts of by-8, by-2 and by-1 primitives.
// Legacy mode only recognises amounts the ALU can do in one step (1, 2, 8).
module shift_step_split #(
    parameter int SHAMT_W    = 5,
    parameter bit ENABLE_SEQ = 1'b1
) (
    input  logic [SHAMT_W-1:0] shamt,
    output logic [SHAMT_W-1:0] n8,
    output logic [1:0]         n2,
    output logic               n1,
    output logic               is_1,
    output logic               is_2,
    output logic               is_8
);

    always_comb begin
        is_1 = (shamt == SHAMT_W'(1));
        is_2 = (shamt == SHAMT_W'(2));
        is_8 = (shamt == SHAMT_W'(8));
        if (ENABLE_SEQ) begin
            n8 = shamt >> 3;
            n2 = shamt[2:1];
            n1 = shamt[0];
        end else begin
            n8 = SHAMT_W'(is_8);
            n2 = {1'b0, is_2};
            n1 = is_1;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder that also sequences arbitrary shifts as chains of
// by-8/by-2/by-1 primitives. Handshake: an op is taken on any rising edge with
// in_valid && in_ready; steps are never stalled, one per cycle while out_valid.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int SHAMT_W    = 5,
    parameter int CTRL_W     = 6,
    parameter bit ENABLE_SEQ = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         functionCode,
    input  logic [4:0]         ALUop,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic               out_feedback,
    output logic               out_last,
    output logic [1:0]         dbg_state
);

    logic [1:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt8_q, cnt8_d;
    logic [1:0]         cnt2_q, cnt2_d;
    logic               cnt1_q, cnt1_d;
    shift_kind_e        kind_q, kind_d;
    logic               out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]  out_ctrl_q, out_ctrl_d;
    logic               out_feedback_q, out_feedback_d;
    logic               out_last_q, out_last_d;

    op_dec_t            dec;
    logic [SHAMT_W-1:0] sp8, src8;
    logic [1:0]         sp2, src2;
    logic               sp1, src1;
    logic               is_1, is_2, is_8;
    logic               accept, shift_nop, take_step;
    logic [1:0]         amt_sel;

    shift_step_split #(
        .SHAMT_W    (SHAMT_W),
        .ENABLE_SEQ (ENABLE_SEQ)
    ) u_split (
        .shamt (Shamt),
        .n8    (sp8),
        .n2    (sp2),
        .n1    (sp1),
        .is_1  (is_1),
        .is_2  (is_2),
        .is_8  (is_8)
    );

    assign dec       = decode_op(ALUop, functionCode);
    assign in_ready  = (state_q == ST_IDLE) || out_last_q;
    assign accept    = in_valid && in_ready;
    assign shift_nop = ENABLE_SEQ ? (Shamt == '0) : !(is_1 || is_2 || is_8);

    always_comb begin
        state_d        = ST_IDLE;
        cnt8_d         = '0;
        cnt2_d         = '0;
        cnt1_d         = 1'b0;
        kind_d         = kind_q;
        out_valid_d    = 1'b0;
        out_ctrl_d     = '0;
        out_feedback_d = 1'b0;
        out_last_d     = 1'b0;
        take_step      = 1'b0;
        src8           = cnt8_q;
        src2           = cnt2_q;
        src1           = cnt1_q;
        amt_sel        = AMT_1;

        if (accept) begin
            kind_d      = dec.kind;
            out_valid_d = 1'b1;
            if (dec.is_shift && !shift_nop) begin
                take_step = 1'b1;
                src8      = sp8;
                src2      = sp2;
                src1      = sp1;
            end else begin
                out_ctrl_d = CTRL_W'(dec.is_shift ? CODE_NOP : dec.code);
                out_last_d = 1'b1;
                state_d    = ST_ISSUE;
            end
        end else if (state_q == ST_RUN && !out_last_q) begin
            take_step      = 1'b1;
            out_valid_d    = 1'b1;
            out_feedback_d = 1'b1;
        end

        // Largest primitive first; counters hold what remains after this step.
        if (take_step) begin
            cnt8_d = src8;
            cnt2_d = src2;
            cnt1_d = src1;
            if (src8 != '0) begin
                amt_sel = AMT_8;
                cnt8_d  = src8 - SHAMT_W'(1);
            end else if (src2 != 2'd0) begin
                amt_sel = AMT_2;
                cnt2_d  = src2 - 2'd1;
            end else begin
                amt_sel = AMT_1;
                cnt1_d  = 1'b0;
            end
            out_ctrl_d = CTRL_W'(prim_code(kind_d, amt_sel));
            out_last_d = (cnt8_d == '0) && (cnt2_d == 2'd0) && !cnt1_d;
            state_d    = (accept && out_last_d) ? ST_ISSUE : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt8_q         <= '0;
            cnt2_q         <= '0;
            cnt1_q         <= 1'b0;
            kind_q         <= SK_SLL;
            out_valid_q    <= 1'b0;
            out_ctrl_q     <= '0;
            out_feedback_q <= 1'b0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt8_q         <= cnt8_d;
            cnt2_q         <= cnt2_d;
            cnt1_q         <= cnt1_d;
            kind_q         <= kind_d;
            out_valid_q    <= out_valid_d;
            out_ctrl_q     <= out_ctrl_d;
            out_feedback_q <= out_feedback_d;
            out_last_q     <= out_last_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_ctrl     = out_ctrl_q;
    assign out_feedback = out_feedback_q;
    assign out_last     = out_last_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: a sequencing instance and a legacy instance fed the
// same accepted ops, each checked against its own expected-step queue.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] functionCode = '0;
    logic [4:0] ALUop = '0;
    logic [4:0] Shamt = '0;

    logic       in_ready, out_valid, out_feedback, out_last;
    logic [5:0] out_ctrl;
    logic [1:0] dbg_state;

    logic       in_valid_l, in_ready_l, out_valid_l, out_feedback_l, out_last_l;
    logic [5:0] out_ctrl_l;
    logic [1:0] dbg_state_l;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    // Each entry is {last, feedback, ctrl[5:0]}.
    logic [7:0] exp_q[$];
    logic [7:0] exp_l_q[$];

    always #5 clk = ~clk;

    // The legacy instance takes exactly the ops the sequencing instance takes.
    assign in_valid_l = in_valid && in_ready;

    alu_ctrl_seq #(.SHAMT_W(5), .CTRL_W(6), .ENABLE_SEQ(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .functionCode(functionCode), .ALUop(ALUop), .Shamt(Shamt),
        .out_valid(out_valid), .out_ctrl(out_ctrl), .out_feedback(out_feedback),
        .out_last(out_last), .dbg_state(dbg_state)
    );

    alu_ctrl_seq #(.SHAMT_W(5), .CTRL_W(6), .ENABLE_SEQ(1'b0)) dut_leg (
        .clk(clk), .reset(reset), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .functionCode(functionCode), .ALUop(ALUop), .Shamt(Shamt),
        .out_valid(out_valid_l), .out_ctrl(out_ctrl_l), .out_feedback(out_feedback_l),
        .out_last(out_last_l), .dbg_state(dbg_state_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_code(input logic [4:0] op, input logic [5:0] fn);
        logic [5:0] c;
        c = 6'h00;
        case (op)
            5'd0: c = 6'h02;
            5'd1: c = 6'h06;
            5'd3: c = 6'h03;
            5'd5: c = 6'h01;
            5'd6: c = 6'h04;
            5'd7: c = 6'h07;
            5'd8: c = 6'h08;
            5'd9: c = 6'h09;
            5'd2: begin
                case (fn)
                    6'h20: c = 6'h02;
                    6'h21: c = 6'h03;
                    6'h23: c = 6'h06;
                    6'h25: c = 6'h01;
                    6'h26: c = 6'h04;
                    6'h2A: c = 6'h07;
                    6'h2B: c = 6'h08;
                    6'h19: c = 6'h13;
                    6'h30: c = 6'h30;
                    6'h32: c = 6'h32;
                    default: c = 6'h00;
                endcase
            end
            default: c = 6'h00;
        endcase
        return c;
    endfunction

    function automatic logic [5:0] prim_ref(input int base, input int amt);
        int off;
        off = (amt == 1) ? 0 : (amt == 2) ? 1 : 2;
        return 6'(base + off);
    endfunction

    task automatic push_model(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh);
        int base;
        int rem;
        int amts[$];
        bit is_sh;
        is_sh = (op == 5'd2) && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
        if (!is_sh) begin
            exp_q.push_back({2'b10, ref_code(op, fn)});
            exp_l_q.push_back({2'b10, ref_code(op, fn)});
            return;
        end
        base = (fn == 6'h00) ? 'h0A : (fn == 6'h02) ? 'h0D : 'h10;
        rem = int'(sh);
        while (rem >= 8) begin amts.push_back(8); rem -= 8; end
        while (rem >= 2) begin amts.push_back(2); rem -= 2; end
        if (rem == 1) amts.push_back(1);
        if (amts.size() == 0) begin
            exp_q.push_back({2'b10, 6'h00});
        end else begin
            for (int i = 0; i < amts.size(); i++)
                exp_q.push_back({(i == amts.size() - 1), (i != 0), prim_ref(base, amts[i])});
        end
        if (sh == 5'd1 || sh == 5'd2 || sh == 5'd8)
            exp_l_q.push_back({2'b10, prim_ref(base, int'(sh))});
        else
            exp_l_q.push_back({2'b10, 6'h00});
    endtask

    always @(negedge clk) begin
        if (!reset && mon_en) begin
            logic [7:0] e;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_step", {out_last, out_feedback, out_ctrl}, 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("step", {out_last, out_feedback, out_ctrl}, e);
                    check_eq("ready_in_chain", in_ready, e[7]);
                end
            end else begin
                check_eq("idle_outputs", {out_feedback, out_ctrl}, 0);
                check_eq("idle_ready", in_ready, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && mon_en) begin
            logic [7:0] e;
            if (out_valid_l) begin
                if (exp_l_q.size() == 0) begin
                    check_eq("leg_unexpected_step", {out_last_l, out_feedback_l, out_ctrl_l}, 32'h1FF);
                end else begin
                    e = exp_l_q.pop_front();
                    check_eq("leg_step", {out_last_l, out_feedback_l, out_ctrl_l}, e);
                    check_eq("leg_ready", in_ready_l, 1);
                end
            end else begin
                check_eq("leg_idle_outputs", {out_feedback_l, out_ctrl_l}, 0);
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh);
        int waited;
        waited = 0;
        @(negedge clk);
        ALUop = op;
        functionCode = fn;
        Shamt = sh;
        in_valid = 1'b1;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        push_model(op, fn, sh);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_l_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq("drain", exp_q.size() + exp_l_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fn_list[16];
        fn_list = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h2A, 6'h2B, 6'h19, 6'h10, 6'h12, 6'h30, 6'h32};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out", {out_valid, out_last, out_feedback, out_ctrl}, 0);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_leg_out", {out_valid_l, out_last_l, out_feedback_l, out_ctrl_l}, 0);
        mon_en = 1'b1;

        send(5'd2, 6'h00, 5'd13);
        drain();
        send(5'd2, 6'h03, 5'd31);
        drain();

        // ADD taken on the cycle SRL by 3 shows its last step.
        send(5'd2, 6'h02, 5'd3);
        send(5'd2, 6'h20, 5'd0);
        @(negedge clk);
        check_eq("no_bubble", {out_valid, out_last, out_feedback, out_ctrl}, {3'b110, 6'h02});
        drain();

        send(5'd2, 6'h00, 5'd0);
        send(5'd2, 6'h02, 5'd8);
        send(5'd9, 6'h00, 5'd0);
        drain();

        // Reset lands while the 2nd step of SLL by 31 is on the outputs.
        send(5'd2, 6'h00, 5'd31);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        exp_l_q.delete();
        @(negedge clk);
        check_eq("abort_out", {out_valid, out_feedback, out_ctrl}, 0);
        check_eq("abort_state", dbg_state, 0);
        #1 reset = 1'b0;
        send(5'd2, 6'h00, 5'd1);
        drain();

        for (int i = 0; i < 80; i++) begin
            logic [4:0] op;
            logic [5:0] fn;
            op = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : 2);
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fn_list[$urandom_range(0, 15)];
            send(op, fn, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
